// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the multi-cycle controller and the memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_read;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, mem_read, mem_write, i_or_d, input mem_ready);
  modport slave  (input mem_req, mem_read, mem_write, i_or_d, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory timeout and retire counter.
// Optional bne decode is enabled by defining CTRL_BNE_EN.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   mem,
  input  logic [5:0]          op,
  input  logic                zero,
  output logic                ir_write,
  output logic                pc_en,
  output logic [1:0]          pc_source,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                ext_op,
  output logic [2:0]          alu_op,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic [2:0]          state,
  output logic                retire,
  output logic                illegal,
  output logic                mem_err,
  output logic [RETIRE_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  // Wait counter only needs to reach MEM_TIMEOUT-1; it wraps harmlessly when the timeout is disabled.
  localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [RETIRE_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic                  timeout_s;

  assign timeout_s  = TIMEOUT_EN && (wait_q == WAIT_LAST) && !mem.mem_ready;
  assign state      = state_q;
  assign retire_cnt = retire_cnt_q;

  // Next-state and control decode; everything stays low while rst is high.
  always_comb begin
    state_d       = state_q;
    wait_d        = '0;
    mem.mem_req   = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    mem.i_or_d    = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_op        = 1'b0;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    retire        = 1'b0;
    illegal       = 1'b0;
    mem_err       = 1'b0;
    if (rst) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem.mem_req  = 1'b1;
          mem.mem_read = 1'b1;
          alu_src_b    = 2'b01;
          if (mem.mem_ready) begin
            ir_write = 1'b1;
            pc_en    = 1'b1;
            state_d  = S_DECODE;
          end else if (timeout_s) begin
            mem_err = 1'b1;
            state_d = S_FETCH;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          ext_op    = 1'b1;
          case (op)
            OP_J: begin
              pc_en     = 1'b1;
              pc_source = 2'b10;
              retire    = 1'b1;
              state_d   = S_FETCH;
            end
            OP_JAL: begin
              pc_en      = 1'b1;
              pc_source  = 2'b10;
              reg_write  = 1'b1;
              reg_dst    = 2'b10;
              mem_to_reg = 2'b10;
              retire     = 1'b1;
              state_d    = S_FETCH;
            end
`ifdef CTRL_BNE_EN
            OP_BNE,
`endif
            OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LW, OP_SW, OP_BEQ: begin
              state_d = S_EXEC;
            end
            default: begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
        S_EXEC: begin
          case (op)
            OP_RTYPE: begin
              alu_src_a = 1'b1;
              alu_op    = ALU_FUNCT;
              state_d   = S_WB;
            end
            OP_ADDI: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              ext_op    = 1'b1;
              state_d   = S_WB;
            end
            OP_ANDI: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              alu_op    = ALU_AND;
              state_d   = S_WB;
            end
            OP_ORI: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              alu_op    = ALU_OR;
              state_d   = S_WB;
            end
            OP_XORI: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              alu_op    = ALU_XOR;
              state_d   = S_WB;
            end
            OP_LUI: begin
              alu_src_b = 2'b10;
              alu_op    = ALU_LUI;
              state_d   = S_WB;
            end
            OP_LW, OP_SW: begin
              alu_src_a = 1'b1;
              alu_src_b = 2'b10;
              ext_op    = 1'b1;
              state_d   = S_MEM;
            end
            OP_BEQ: begin
              alu_src_a = 1'b1;
              alu_op    = ALU_SUB;
              pc_source = 2'b01;
              pc_en     = zero;
              retire    = 1'b1;
              state_d   = S_FETCH;
            end
`ifdef CTRL_BNE_EN
            OP_BNE: begin
              alu_src_a = 1'b1;
              alu_op    = ALU_SUB;
              pc_source = 2'b01;
              pc_en     = ~zero;
              retire    = 1'b1;
              state_d   = S_FETCH;
            end
`endif
            default: begin
              state_d = S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          mem.mem_req   = 1'b1;
          mem.i_or_d    = 1'b1;
          mem.mem_read  = (op == OP_LW);
          mem.mem_write = (op == OP_SW);
          if (mem.mem_ready) begin
            if (op == OP_LW) begin
              state_d = S_WB;
            end else begin
              retire  = (op == OP_SW);
              state_d = S_FETCH;
            end
          end else if (timeout_s) begin
            mem_err = 1'b1;
            state_d = S_FETCH;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          if (op == OP_RTYPE) begin
            reg_dst = 2'b01;
          end else begin
            reg_dst = 2'b00;
          end
          if (op == OP_LW) begin
            mem_to_reg = 2'b01;
          end else begin
            mem_to_reg = 2'b00;
          end
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // Retire counter wraps modulo 2^RETIRE_W.
  always_comb begin
    if (retire) begin
      retire_cnt_d = retire_cnt_q + RETIRE_W'(1);
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  // State, wait counter and retire counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      wait_q       <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT=4, RETIRE_W=4 to reach the boundaries quickly).
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       ir_write, pc_en, alu_src_a, ext_op, reg_write;
  logic       retire, illegal, mem_err;
  logic [1:0] pc_source, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0] alu_op, state;
  logic [3:0] retire_cnt;
  logic [3:0] exp_cnt;
  logic [22:0] ctl;
  int errors = 0;
  int checks = 0;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.MEM_TIMEOUT(4), .RETIRE_W(4)) dut (
    .clk(clk), .rst(rst), .mem(mif), .op(op), .zero(zero),
    .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .state(state), .retire(retire),
    .illegal(illegal), .mem_err(mem_err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {mif.mem_req, mif.mem_read, mif.mem_write, mif.i_or_d, ir_write, pc_en,
                pc_source, alu_src_a, alu_src_b, ext_op, alu_op, reg_write, reg_dst,
                mem_to_reg, retire, illegal, mem_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 6'b000000; zero = 1'b0; mif.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({state, retire_cnt} !== {3'd0, 4'd0}) begin
      $display("FAIL reset_state: got state=%0d cnt=%0d want 0 0", state, retire_cnt); errors++;
    end
    checks++;
    if (ctl !== 23'd0) begin
      $display("FAIL reset_outputs: got %h want 0", ctl); errors++;
    end
    rst = 1'b0; exp_cnt = 4'd0;
    #1;
    checks++;
    if ({mif.mem_req, mif.mem_read, mif.i_or_d, alu_src_b, alu_op} !== {1'b1, 1'b1, 1'b0, 2'b01, 3'b000}) begin
      $display("FAIL first_req: got %b%b%b %b %b", mif.mem_req, mif.mem_read, mif.i_or_d, alu_src_b, alu_op); errors++;
    end
  endtask

  task automatic test_rtype();
    op = 6'b000000; mif.mem_ready = 1'b1;
    #1;
    checks++;
    if ({state, ir_write, pc_en, pc_source} !== {3'd0, 1'b1, 1'b1, 2'b00}) begin
      $display("FAIL rtype_fetch: got %0d %b%b %b", state, ir_write, pc_en, pc_source); errors++;
    end
    tick();
    checks++;
    if ({state, alu_src_b, ext_op, alu_op} !== {3'd1, 2'b11, 1'b1, 3'b000}) begin
      $display("FAIL rtype_decode: got %0d %b %b %b", state, alu_src_b, ext_op, alu_op); errors++;
    end
    tick();
    checks++;
    if ({state, alu_src_a, alu_src_b, alu_op} !== {3'd2, 1'b1, 2'b00, 3'b111}) begin
      $display("FAIL rtype_exec: got %0d %b %b %b", state, alu_src_a, alu_src_b, alu_op); errors++;
    end
    tick();
    checks++;
    if ({state, reg_write, reg_dst, mem_to_reg, retire} !== {3'd4, 1'b1, 2'b01, 2'b00, 1'b1}) begin
      $display("FAIL rtype_wb: got %0d %b %b %b %b", state, reg_write, reg_dst, mem_to_reg, retire); errors++;
    end
    tick(); exp_cnt = exp_cnt + 4'd1;
    checks++;
    if ({state, retire_cnt} !== {3'd0, exp_cnt}) begin
      $display("FAIL rtype_done: got state=%0d cnt=%0d want 0 %0d", state, retire_cnt, exp_cnt); errors++;
    end
  endtask

  task automatic test_lw_wait();
    op = 6'b100011; mif.mem_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({state, alu_src_a, alu_src_b, ext_op, alu_op} !== {3'd2, 1'b1, 2'b10, 1'b1, 3'b000}) begin
      $display("FAIL lw_exec: got %0d %b %b %b %b", state, alu_src_a, alu_src_b, ext_op, alu_op); errors++;
    end
    mif.mem_ready = 1'b0;
    tick();
    checks++;
    if ({state, mif.mem_req, mif.mem_read, mif.mem_write, mif.i_or_d, mem_err} !== {3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL lw_mem: got %0d %b%b%b%b %b", state, mif.mem_req, mif.mem_read, mif.mem_write, mif.i_or_d, mem_err); errors++;
    end
    tick(); tick(); tick();
    mif.mem_ready = 1'b1;
    #1;
    checks++;
    if ({state, mem_err, retire} !== {3'd3, 1'b0, 1'b0}) begin
      $display("FAIL lw_ready_wins: got %0d err=%b ret=%b", state, mem_err, retire); errors++;
    end
    tick();
    checks++;
    if ({state, reg_write, reg_dst, mem_to_reg, retire} !== {3'd4, 1'b1, 2'b00, 2'b01, 1'b1}) begin
      $display("FAIL lw_wb: got %0d %b %b %b %b", state, reg_write, reg_dst, mem_to_reg, retire); errors++;
    end
    tick(); exp_cnt = exp_cnt + 4'd1;
    checks++;
    if ({state, retire_cnt} !== {3'd0, exp_cnt}) begin
      $display("FAIL lw_done: got state=%0d cnt=%0d want 0 %0d", state, retire_cnt, exp_cnt); errors++;
    end
  endtask

  task automatic test_beq();
    op = 6'b000100; zero = 1'b1; mif.mem_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({state, alu_src_a, alu_src_b, alu_op, pc_source, pc_en, retire} !== {3'd2, 1'b1, 2'b00, 3'b001, 2'b01, 1'b1, 1'b1}) begin
      $display("FAIL beq_taken: got %0d %b %b %b %b %b %b", state, alu_src_a, alu_src_b, alu_op, pc_source, pc_en, retire); errors++;
    end
    tick(); exp_cnt = exp_cnt + 4'd1;
    checks++;
    if ({state, retire_cnt} !== {3'd0, exp_cnt}) begin
      $display("FAIL beq_taken_done: got state=%0d cnt=%0d want 0 %0d", state, retire_cnt, exp_cnt); errors++;
    end
    zero = 1'b0;
    tick(); tick();
    checks++;
    if ({state, pc_en, retire} !== {3'd2, 1'b0, 1'b1}) begin
      $display("FAIL beq_not_taken: got %0d pc_en=%b ret=%b", state, pc_en, retire); errors++;
    end
    tick(); exp_cnt = exp_cnt + 4'd1;
    checks++;
    if ({state, retire_cnt} !== {3'd0, exp_cnt}) begin
      $display("FAIL beq_nt_done: got state=%0d cnt=%0d want 0 %0d", state, retire_cnt, exp_cnt); errors++;
    end
  endtask

  task automatic test_jal();
    op = 6'b000011; mif.mem_ready = 1'b1;
    tick();
    checks++;
    if ({state, pc_en, pc_source, reg_write, reg_dst, mem_to_reg, retire} !== {3'd1, 1'b1, 2'b10, 1'b1, 2'b10, 2'b10, 1'b1}) begin
      $display("FAIL jal_decode: got %0d %b %b %b %b %b %b", state, pc_en, pc_source, reg_write, reg_dst, mem_to_reg, retire); errors++;
    end
    tick(); exp_cnt = exp_cnt + 4'd1;
    checks++;
    if ({state, retire_cnt} !== {3'd0, exp_cnt}) begin
      $display("FAIL jal_done: got state=%0d cnt=%0d want 0 %0d", state, retire_cnt, exp_cnt); errors++;
    end
  endtask

  task automatic test_bne();
    op = 6'b000101; zero = 1'b0; mif.mem_ready = 1'b1;
    tick();
`ifdef CTRL_BNE_EN
    tick();
    checks++;
    if ({state, pc_en, pc_source, retire, illegal} !== {3'd2, 1'b1, 2'b01, 1'b1, 1'b0}) begin
      $display("FAIL bne_exec: got %0d %b %b %b %b", state, pc_en, pc_source, retire, illegal); errors++;
    end
    exp_cnt = exp_cnt + 4'd1;
`else
    checks++;
    if ({state, illegal, retire, reg_write, pc_en} !== {3'd1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL bne_illegal: got %0d %b %b %b %b", state, illegal, retire, reg_write, pc_en); errors++;
    end
`endif
    tick();
    checks++;
    if ({state, retire_cnt, illegal} !== {3'd0, exp_cnt, 1'b0}) begin
      $display("FAIL bne_done: got state=%0d cnt=%0d ill=%b want 0 %0d 0", state, retire_cnt, illegal, exp_cnt); errors++;
    end
  endtask

  task automatic test_iarith();
    logic [5:0] ops [5] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
    logic [6:0] exp [5] = '{{1'b1, 2'b10, 1'b1, 3'b000}, {1'b1, 2'b10, 1'b0, 3'b010},
                            {1'b1, 2'b10, 1'b0, 3'b011}, {1'b1, 2'b10, 1'b0, 3'b100},
                            {1'b0, 2'b10, 1'b0, 3'b101}};
    mif.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op = ops[i];
      tick(); tick();
      checks++;
      if ({state, alu_src_a, alu_src_b, ext_op, alu_op} !== {3'd2, exp[i]}) begin
        $display("FAIL iarith_exec op=%b: got %0d %b %b %b %b want %b", op, state, alu_src_a, alu_src_b, ext_op, alu_op, exp[i]); errors++;
      end
      tick();
      checks++;
      if ({state, reg_write, reg_dst, mem_to_reg, retire} !== {3'd4, 1'b1, 2'b00, 2'b00, 1'b1}) begin
        $display("FAIL iarith_wb op=%b: got %0d %b %b %b %b", op, state, reg_write, reg_dst, mem_to_reg, retire); errors++;
      end
      tick(); exp_cnt = exp_cnt + 4'd1;
      checks++;
      if ({state, retire_cnt} !== {3'd0, exp_cnt}) begin
        $display("FAIL iarith_done op=%b: got %0d cnt=%0d want %0d", op, state, retire_cnt, exp_cnt); errors++;
      end
    end
  endtask

  task automatic test_sw();
    op = 6'b101011; mif.mem_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({state, mif.mem_req, mif.mem_write, mif.mem_read, mif.i_or_d, retire, reg_write} !== {3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL sw_mem: got %0d %b%b%b%b ret=%b rw=%b", state, mif.mem_req, mif.mem_write, mif.mem_read, mif.i_or_d, retire, reg_write); errors++;
    end
    tick(); exp_cnt = exp_cnt + 4'd1;
    checks++;
    if ({state, retire_cnt} !== {3'd0, exp_cnt}) begin
      $display("FAIL sw_done: got state=%0d cnt=%0d want 0 %0d", state, retire_cnt, exp_cnt); errors++;
    end
  endtask

  task automatic test_timeout();
    op = 6'b000000; mif.mem_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        #1;
        checks++;
        if ({state, mem_err} !== {3'd0, 1'b0}) begin
          $display("FAIL fetch_wait r=%0d c=%0d: got state=%0d err=%b", r, c, state, mem_err); errors++;
        end
        tick();
      end
      checks++;
      if ({state, mem_err, ir_write, pc_en, reg_write, retire} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        $display("FAIL fetch_timeout r=%0d: got %0d err=%b %b%b%b%b", r, state, mem_err, ir_write, pc_en, reg_write, retire); errors++;
      end
      tick();
    end
    op = 6'b101011; mif.mem_ready = 1'b1;
    #1;
    tick(); tick();
    mif.mem_ready = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if ({state, mem_err, retire, reg_write} !== {3'd3, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL mem_timeout: got %0d err=%b ret=%b rw=%b", state, mem_err, retire, reg_write); errors++;
    end
    tick();
    checks++;
    if ({state, retire_cnt, mem_err} !== {3'd0, exp_cnt, 1'b0}) begin
      $display("FAIL mem_timeout_done: got state=%0d cnt=%0d err=%b want 0 %0d 0", state, retire_cnt, mem_err, exp_cnt); errors++;
    end
  endtask

  task automatic test_reset_mid();
    op = 6'b100011; mif.mem_ready = 1'b1;
    tick(); tick();
    mif.mem_ready = 1'b0;
    tick();
    checks++;
    if ({state, mif.mem_req, mif.mem_read} !== {3'd3, 1'b1, 1'b1}) begin
      $display("FAIL pre_reset_mem: got %0d %b%b", state, mif.mem_req, mif.mem_read); errors++;
    end
    #2 rst = 1'b1;
    #1;
    exp_cnt = 4'd0;
    checks++;
    if ({state, retire_cnt, ctl} !== {3'd0, exp_cnt, 23'd0}) begin
      $display("FAIL reset_mid: got state=%0d cnt=%0d ctl=%h want 0 0 0", state, retire_cnt, ctl); errors++;
    end
    tick();
    rst = 1'b0; mif.mem_ready = 1'b1;
    #1;
  endtask

  task automatic test_wrap();
    op = 6'b000010; mif.mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if ({state, pc_en, pc_source, retire, reg_write} !== {3'd1, 1'b1, 2'b10, 1'b1, 1'b0}) begin
        $display("FAIL j_decode i=%0d: got %0d %b %b %b %b", i, state, pc_en, pc_source, retire, reg_write); errors++;
      end
      tick(); exp_cnt = exp_cnt + 4'd1;
    end
    checks++;
    if ({state, retire_cnt} !== {3'd0, 4'd0}) begin
      $display("FAIL retire_wrap: got state=%0d cnt=%0d want 0 0 (model %0d)", state, retire_cnt, exp_cnt); errors++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_jal();
    test_bne();
    test_iarith();
    test_sw();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
